// File: rtl/data_mem_responder_if.sv
// Data-memory request/response bundle shared by the core (master) and the
// memory responder (slave).
interface data_mem_responder_if #(
  parameter int ADDR_W = 32
);
  logic              MemReq;
  logic              MemWrite;
  logic [ADDR_W-1:0] Addr;
  logic [31:0]       WriteData;
  logic              ReqReady;
  logic              RespValid;
  logic [31:0]       ReadData;
  logic              RespErr;

  modport master (
    output MemReq, MemWrite, Addr, WriteData,
    input  ReqReady, RespValid, ReadData, RespErr
  );

  modport slave (
    input  MemReq, MemWrite, Addr, WriteData,
    output ReqReady, RespValid, ReadData, RespErr
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data-memory responder with a fixed number of wait states.
// One request is accepted per transaction. Exactly one single-cycle response
// strobe follows it, WAIT_CYCLES cycles after the accept edge. A request can be
// accepted during the response cycle, so back-to-back traffic gets one
// response every WAIT_CYCLES+1 cycles.
// Optional macro RESP_ERR_EN enables error flagging for misaligned or
// out-of-range addresses. When it is undefined, addresses wrap modulo DEPTH
// words and RespErr stays 0.
module data_mem_responder #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 32
) (
  input  logic                 CLK,
  input  logic                 Reset,
  data_mem_responder_if.slave  bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT =
    (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;

  // Request fields latched at the accept edge.
  logic               write_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic [31:0]        data_reg;
  logic               err_reg;

  logic [31:0]        read_data_reg;
  logic               resp_err_reg;
  logic [31:0]        mem [DEPTH];

  logic               accept;
  logic [IDX_W-1:0]   req_idx;
  logic               req_flag;
  logic               commit;
  logic               c_write;
  logic [IDX_W-1:0]   c_idx;
  logic [31:0]        c_data;
  logic               c_flag;

  assign accept  = bus.MemReq && bus.ReqReady;
  assign req_idx = bus.Addr[IDX_W+1:2];

`ifdef RESP_ERR_EN
  localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W + 1)'(DEPTH * 4);
  assign req_flag = (bus.Addr[1:0] != 2'b00) || ({1'b0, bus.Addr} >= ADDR_LIMIT);
`else
  // Byte-offset bits and bits above the index take no part in wrapped addressing.
  logic unused_addr;
  assign unused_addr = ^{bus.Addr[ADDR_W-1:IDX_W+2], bus.Addr[1:0]};
  assign req_flag    = 1'b0;
`endif

  // The edge that moves into RESP is the one that commits the transaction.
  // With no wait states, this is the accept edge, so the live request fields
  // are used. Otherwise the latched fields are used.
  assign commit  = (state_next == RESP);
  assign c_write = (WAIT_CYCLES == 0) ? bus.MemWrite  : write_reg;
  assign c_idx   = (WAIT_CYCLES == 0) ? req_idx       : idx_reg;
  assign c_data  = (WAIT_CYCLES == 0) ? bus.WriteData : data_reg;
  assign c_flag  = (WAIT_CYCLES == 0) ? req_flag      : err_reg;

  assign bus.ReqReady  = (state_reg != WAIT);
  assign bus.RespValid = (state_reg == RESP);
  assign bus.ReadData  = read_data_reg;
  assign bus.RespErr   = resp_err_reg;

  // State register and wait-state counter.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic: accept from IDLE or RESP, count down in WAIT.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE, RESP: begin
        if (accept) begin
          state_next = (WAIT_CYCLES == 0) ? RESP : WAIT;
          cnt_next   = CNT_INIT;
        end else begin
          state_next = IDLE;
        end
      end
      WAIT: begin
        if (cnt_reg == '0) state_next = RESP;
        else               cnt_next   = cnt_reg - CNT_W'(1);
      end
      default: state_next = IDLE;
    endcase
  end

  // Capture the request fields on the accept edge.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      write_reg <= 1'b0;
      idx_reg   <= '0;
      data_reg  <= '0;
      err_reg   <= 1'b0;
    end else if (accept) begin
      write_reg <= bus.MemWrite;
      idx_reg   <= req_idx;
      data_reg  <= bus.WriteData;
      err_reg   <= req_flag;
    end
  end

  // Storage array. It is not reset, and flagged stores are dropped.
  always_ff @(posedge CLK) begin
    if (commit && c_write && !c_flag) mem[c_idx] <= c_data;
  end

  // Load data and error flag, registered on the edge that enters RESP.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      read_data_reg <= '0;
      resp_err_reg  <= 1'b0;
    end else begin
      resp_err_reg <= commit && c_flag;
      if (commit && !c_write) read_data_reg <= c_flag ? '0 : mem[c_idx];
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder. The main instance has WAIT_CYCLES=2,
// and a second instance has WAIT_CYCLES=0 for back-to-back streaming.
// Expected values follow RESP_ERR_EN when that macro is defined.
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

`ifdef RESP_ERR_EN
  localparam logic [31:0] WRAP_RD = 32'h1111_1111;
  localparam logic [31:0] MIS_RD  = 32'h0000_0000;
  localparam logic        ERR_ON  = 1'b1;
`else
  localparam logic [31:0] WRAP_RD = 32'hA5A5_A5A5;
  localparam logic [31:0] MIS_RD  = 32'hA5A5_A5A5;
  localparam logic        ERR_ON  = 1'b0;
`endif

  data_mem_responder_if #(.ADDR_W(32)) b  ();
  data_mem_responder_if #(.ADDR_W(32)) b0 ();

  data_mem_responder #(.DEPTH(64), .WAIT_CYCLES(2), .ADDR_W(32)) dut (
    .CLK(clk), .Reset(rst), .bus(b)
  );
  data_mem_responder #(.DEPTH(64), .WAIT_CYCLES(0), .ADDR_W(32)) dut0 (
    .CLK(clk), .Reset(rst), .bus(b0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction on the WAIT_CYCLES=2 instance, starting from IDLE.
  task automatic txn(input string tag, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_err);
    b.MemReq = 1'b1; b.MemWrite = w; b.Addr = a; b.WriteData = d;
    step();
    b.MemReq = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_wait_ready"}, b.ReqReady, 0);
      chk({tag, "_wait_valid"}, b.RespValid, 0);
      step();
    end
    chk({tag, "_resp_valid"}, b.RespValid, 1);
    chk({tag, "_resp_ready"}, b.ReqReady, 1);
    chk({tag, "_resp_data"}, b.ReadData, exp_rd);
    chk({tag, "_resp_err"}, b.RespErr, exp_err);
    step();
    chk({tag, "_idle_valid"}, b.RespValid, 0);
    chk({tag, "_idle_err"}, b.RespErr, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    b.MemReq = 1'b0;  b.MemWrite = 1'b0;  b.Addr = '0;  b.WriteData = '0;
    b0.MemReq = 1'b0; b0.MemWrite = 1'b0; b0.Addr = '0; b0.WriteData = '0;
    #2;
    chk("rst_ready", b.ReqReady, 1);
    chk("rst_valid", b.RespValid, 0);
    chk("rst_data", b.ReadData, 0);
    chk("rst_err", b.RespErr, 0);
    step(); step();
    rst = 1'b0;
    step();
    chk("post_rst_ready", b.ReqReady, 1);
    chk("post_rst_valid", b.RespValid, 0);

    // Basic store, then load back.
    txn("st_10", 1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0);
    txn("ld_10", 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);

    // A store, followed by a load presented during the store's response cycle.
    b.MemReq = 1'b1; b.MemWrite = 1'b1; b.Addr = 32'h20; b.WriteData = 32'h1234_5678;
    step();
    b.MemReq = 1'b0;
    chk("b2b_st_wait_ready", b.ReqReady, 0);
    step(); step();
    chk("b2b_st_resp_valid", b.RespValid, 1);
    chk("b2b_st_resp_data", b.ReadData, 32'hDEAD_BEEF);
    b.MemReq = 1'b1; b.MemWrite = 1'b0; b.Addr = 32'h20;
    step();
    b.MemReq = 1'b0;
    chk("b2b_ld_wait1_valid", b.RespValid, 0);
    chk("b2b_ld_wait1_ready", b.ReqReady, 0);
    step();
    chk("b2b_ld_wait2_valid", b.RespValid, 0);
    step();
    chk("b2b_ld_resp_valid", b.RespValid, 1);
    chk("b2b_ld_resp_data", b.ReadData, 32'h1234_5678);
    step();
    chk("b2b_idle_valid", b.RespValid, 0);

    // Address wrap and, with RESP_ERR_EN defined, error flagging.
    txn("st_04", 1'b1, 32'h04, 32'h1111_1111, 32'h1234_5678, 1'b0);
    txn("st_104", 1'b1, 32'h104, 32'hA5A5_A5A5, 32'h1234_5678, ERR_ON);
    txn("ld_04", 1'b0, 32'h04, 32'h0, WRAP_RD, 1'b0);
    txn("ld_06", 1'b0, 32'h06, 32'h0, MIS_RD, ERR_ON);

    // Reset during the WAIT state of a second store drops that store.
    txn("st_30a", 1'b1, 32'h30, 32'h1, MIS_RD, 1'b0);
    b.MemReq = 1'b1; b.MemWrite = 1'b1; b.Addr = 32'h30; b.WriteData = 32'h2;
    step();
    b.MemReq = 1'b0;
    chk("midrst_wait_ready", b.ReqReady, 0);
    #2 rst = 1'b1;
    #1;
    chk("midrst_ready", b.ReqReady, 1);
    chk("midrst_valid", b.RespValid, 0);
    chk("midrst_data", b.ReadData, 0);
    chk("midrst_err", b.RespErr, 0);
    step(); step();
    rst = 1'b0;
    chk("midrst_rel_ready", b.ReqReady, 1);
    chk("midrst_rel_valid", b.RespValid, 0);
    chk("midrst_rel_data", b.ReadData, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("midrst_no_resp", b.RespValid, 0);
    end
    txn("ld_30", 1'b0, 32'h30, 32'h0, 32'h1, 1'b0);

    // Zero wait states with MemReq held high: four consecutive responses.
    chk("z_pre_valid", b0.RespValid, 0);
    b0.MemReq = 1'b1; b0.MemWrite = 1'b1; b0.Addr = 32'h08; b0.WriteData = 32'h77;
    step();
    chk("z1_valid", b0.RespValid, 1);
    chk("z1_ready", b0.ReqReady, 1);
    chk("z1_data", b0.ReadData, 0);
    b0.Addr = 32'h0C; b0.WriteData = 32'h88;
    step();
    chk("z2_valid", b0.RespValid, 1);
    chk("z2_ready", b0.ReqReady, 1);
    chk("z2_data", b0.ReadData, 0);
    b0.MemWrite = 1'b0; b0.Addr = 32'h08;
    step();
    chk("z3_valid", b0.RespValid, 1);
    chk("z3_ready", b0.ReqReady, 1);
    chk("z3_data", b0.ReadData, 32'h77);
    b0.Addr = 32'h0C;
    step();
    chk("z4_valid", b0.RespValid, 1);
    chk("z4_ready", b0.ReqReady, 1);
    chk("z4_data", b0.ReadData, 32'h88);
    b0.MemReq = 1'b0;
    step();
    chk("z_end_valid", b0.RespValid, 0);
    chk("z_end_ready", b0.ReqReady, 1);
    chk("z_end_data", b0.ReadData, 32'h88);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
